// File: rtl/booth_pkg.sv
// booth_seq_mult shared types
// FSM state encoding and Booth op decode
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } op_e;

  function automatic op_e booth_op(
    input logic q0,
    input logic qm1
  );
    op_e op;
    op = OP_NOP;
    unique case (1'b1)
      (q0 == 1'b0) && (qm1 == 1'b1): op = OP_ADD;
      (q0 == 1'b1) && (qm1 == 1'b0): op = OP_SUB;
      default:                       op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult request/response bundle
// master issues operands, slave returns product
interface booth_if #(
  parameter int WIDTH = 32
) ();
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode,
    output multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode,
    input  multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_mult_ctrl.sv
// booth_seq_mult controller
// IDLE/RUN/DONE FSM plus iteration counter
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               count_is_one;

  assign count_is_one = (cnt_q == CNT_W'(1));

  // state and counter registers, sync reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, counter and datapath strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = CNT_W'(WIDTH + 1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (count_is_one) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN) ||
                (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult top: radix-2 Booth datapath
// A/M/Q/Q-1 registers driven by booth_ctrl
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input logic  clk,
  input logic  reset_n,
  booth_if.slave bus
);

  localparam int W1 = WIDTH + 1;

  logic               load, step, finish;
  logic               busy, done;
  logic [W1:0]        a_q, a_d;
  logic [W1:0]        a_sum, m_x;
  logic [W1-1:0]      m_q, m_d;
  logic [W1-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               ext_mc, ext_mp;
  op_e                op;

  booth_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bus.start),
    .load    (load),
    .step    (step),
    .finish  (finish),
    .busy    (busy),
    .done    (done)
  );

  // datapath registers, sync reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      m_q    <= m_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      prod_q <= prod_d;
    end
  end

  // operand load, Booth add/sub and arithmetic shift
  always_comb begin
    a_d    = a_q;
    m_d    = m_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    prod_d = prod_q;
    ext_mc = bus.signed_mode &
             bus.multiplicand[WIDTH-1];
    ext_mp = bus.signed_mode &
             bus.multiplier[WIDTH-1];
    op     = booth_op(q_q[0], qm1_q);
    m_x    = {m_q[W1-1], m_q};
    a_sum  = a_q;
    unique case (op)
      OP_ADD:  a_sum = a_q + m_x;
      OP_SUB:  a_sum = a_q - m_x;
      default: a_sum = a_q;
    endcase
    if (load) begin
      m_d   = {ext_mc, bus.multiplicand};
      q_d   = {ext_mp, bus.multiplier};
      a_d   = '0;
      qm1_d = 1'b0;
    end else if (step) begin
      a_d   = {a_sum[W1], a_sum[W1:1]};
      q_d   = {a_sum[0], q_q[W1-1:1]};
      qm1_d = q_q[0];
      if (finish) begin
        prod_d = {a_d[WIDTH-2:0], q_d};
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// booth_seq_mult scoreboard bench
// WIDTH 8 directed, WIDTH 24/32 random
module tb_booth_seq_mult;

  typedef struct {
    logic [127:0] p;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done8 = 0;
  exp_t q8[$];
  exp_t q24[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_if #(.WIDTH(8))  b8  ();
  booth_if #(.WIDTH(24)) b24 ();
  booth_if #(.WIDTH(32)) b32 ();

  booth_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .bus(b8)
  );
  booth_seq_mult #(.WIDTH(24)) u24 (
    .clk(clk), .reset_n(reset_n), .bus(b24)
  );
  booth_seq_mult #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .bus(b32)
  );

  function automatic logic [127:0] ref_mul(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w,
    input logic        s
  );
    logic [127:0] ea, eb, hi, p;
    hi = ~((128'd1 << w) - 128'd1);
    ea = {64'd0, a};
    eb = {64'd0, b};
    if (s && a[w-1]) ea = ea | hi;
    if (s && b[w-1]) eb = eb | hi;
    p = ea * eb;
    return p & ((128'd1 << (2 * w)) - 128'd1);
  endfunction

  task automatic check(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or stray event", nm);
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      8:       return b8.busy;
      24:      return b24.busy;
      default: return b32.busy;
    endcase
  endfunction

  task automatic drive(
    input int          w,
    input logic        s,
    input logic        st,
    input logic [63:0] a,
    input logic [63:0] b
  );
    case (w)
      8: begin
        b8.start = st; b8.signed_mode = s;
        b8.multiplicand = a[7:0];
        b8.multiplier = b[7:0];
      end
      24: begin
        b24.start = st; b24.signed_mode = s;
        b24.multiplicand = a[23:0];
        b24.multiplier = b[23:0];
      end
      default: begin
        b32.start = st; b32.signed_mode = s;
        b32.multiplicand = a[31:0];
        b32.multiplier = b[31:0];
      end
    endcase
  endtask

  task automatic issue(
    input int           w,
    input logic         s,
    input logic [63:0]  a,
    input logic [63:0]  b,
    input logic [127:0] e
  );
    int   n;
    exp_t x;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_of(w) && n < 400);
    if (busy_of(w)) begin
      bad($sformatf("issue_wait_w%0d", w));
      return;
    end
    drive(w, s, 1'b1, a, b);
    @(posedge clk);
    #1;
    x.p = e;
    x.t = cyc;
    case (w)
      8:       q8.push_back(x);
      24:      q24.push_back(x);
      default: q32.push_back(x);
    endcase
    drive(w, s, 1'b0, a, b);
  endtask

  task automatic mon(
    input int           w,
    input logic [127:0] prod
  );
    exp_t x;
    int   sz;
    case (w)
      8:       sz = q8.size();
      24:      sz = q24.size();
      default: sz = q32.size();
    endcase
    if (sz == 0) begin
      bad($sformatf("unexpected_done_w%0d", w));
    end else begin
      case (w)
        8:       x = q8.pop_front();
        24:      x = q24.pop_front();
        default: x = q32.pop_front();
      endcase
      check($sformatf("product_w%0d", w),
            prod, x.p);
      check($sformatf("latency_w%0d", w),
            128'(cyc + 1 - x.t), 128'(w + 2));
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && b8.done === 1'b1) begin
      done8++;
      mon(8, 128'(b8.product));
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && b24.done === 1'b1)
      mon(24, 128'(b24.product));
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && b32.done === 1'b1)
      mon(32, 128'(b32.product));
  end

  task automatic rand_run(input int w);
    logic [63:0] mask, a, b;
    mask = (64'd1 << w) - 64'd1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        a = {32'($urandom), 32'($urandom)} & mask;
        b = {32'($urandom), 32'($urandom)} & mask;
        if (i == 0) begin
          a = 64'd1 << (w - 1);
          b = a;
        end else if (i == 1) begin
          a = mask;
          b = mask;
        end
        issue(w, s[0], a, b, ref_mul(a, b, w, s[0]));
      end
    end
  endtask

  initial begin
    int n;
    int d0;
    bit found;
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(24, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(b8.busy), 128'd0);
    check("rst_done", 128'(b8.done), 128'd0);
    check("rst_product", 128'(b8.product), 128'd0);
    check("rst_product_w32", 128'(b32.product), 128'd0);
    reset_n = 1'b1;

    issue(8, 1'b1, 64'd3, 64'd5, 128'h000F);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b8.busy) n++;
      else break;
    end
    check("busy_cycles", 128'(n), 128'd10);

    issue(8, 1'b1, 64'hF9, 64'h06, 128'hFFD6);
    issue(8, 1'b1, 64'h80, 64'h80, 128'h4000);
    issue(8, 1'b0, 64'hFF, 64'hFF, 128'hFE01);
    issue(8, 1'b0, 64'h80, 64'h02, 128'h0100);
    issue(8, 1'b0, 64'hFF, 64'h01, 128'h00FF);
    issue(8, 1'b1, 64'hFF, 64'h01, 128'hFFFF);

    issue(8, 1'b1, 64'd0, 64'd0, 128'h0000);
    repeat (12) @(negedge clk);
    d0 = done8;
    issue(8, 1'b1, 64'd12, 64'd12, 128'h0090);
    repeat (3) @(negedge clk);
    drive(8, 1'b1, 1'b1, 64'd99, 64'd99);
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 64'd99, 64'd99);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b8.done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bad("hs_done_wait");
    drive(8, 1'b1, 1'b1, 64'd99, 64'd99);
    @(posedge clk);
    #1;
    drive(8, 1'b1, 1'b0, 64'd99, 64'd99);
    repeat (3) @(negedge clk);
    check("hs_idle", 128'(b8.busy), 128'd0);
    check("hs_product", 128'(b8.product), 128'h0090);
    check("hs_pulses", 128'(done8 - d0), 128'd1);

    issue(8, 1'b1, 64'h07, 64'hFD, 128'hFFEB);

    issue(8, 1'b1, 64'd100, 64'd100, 128'h2710);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 128'(b8.busy), 128'd0);
    check("mid_rst_done", 128'(b8.done), 128'd0);
    check("mid_rst_product",
          128'(b8.product), 128'd0);
    reset_n = 1'b1;
    q8.delete();
    d0 = done8;
    repeat (30) @(negedge clk);
    check("no_done_after_rst",
          128'(done8 - d0), 128'd0);
    issue(8, 1'b1, 64'd2, 64'd3, 128'h0006);

    fork
      rand_run(24);
      rand_run(32);
    join

    n = 0;
    while ((q8.size() + q24.size() + q32.size()) != 0
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((q8.size() + q24.size() + q32.size()) != 0)
      bad("drain");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
